vote_input_conditioner: RTL and testbench

- Front-end stage directly upstream of the voting machine. Takes four raw voter push-buttons and delivers clean single-cycle one-hot `vote_inp` pulses, one per physical press.
- Synchronizes, debounces, enforces one vote per press with a release lockout, and flags multi-button presses instead of forwarding them.
- Keeps a saturating count of accepted votes for status display.

---
 rtl/vote_input_conditioner.sv | 121 ++++++++++++
 tb/tb_vote_input_conditioner.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vote_input_conditioner.sv
// Conditions four raw voter buttons into clean one-hot vote pulses:
// synchronize, debounce, one vote per press with release lockout, saturating tally.
module vote_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned LOCKOUT_CYCLES  = 2,
    parameter int unsigned COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               RESET,
    input  logic [3:0]         btn,
    output logic [3:0]         vote_inp,
    output logic               vote_strobe,
    output logic               multi_press,
    output logic               busy,
    output logic [COUNT_W-1:0] vote_count
);

    localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES <= 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned LCNT_W = (LOCKOUT_CYCLES <= 2) ? 1 : $clog2(LOCKOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        EMIT,
        WAIT_RELEASE
    } state_t;

    state_t             state;
    logic [3:0]         sync_1;
    logic [3:0]         btn_s;
    logic [3:0]         cand;
    logic [CNT_W-1:0]   cnt;
    logic [LCNT_W-1:0]  lcnt;
    logic               cand_onehot;

    // Two-flop synchronizer; everything downstream looks only at btn_s.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            sync_1 <= 4'b0000;
            btn_s  <= 4'b0000;
        end else begin
            sync_1 <= btn;
            btn_s  <= sync_1;
        end
    end

    assign cand_onehot = (cand != 4'b0000) && ((cand & (cand - 4'd1)) == 4'b0000);

    // Vote outputs are loaded on the DEBOUNCE->EMIT edge so they are valid during EMIT.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            cand        <= 4'b0000;
            cnt         <= '0;
            lcnt        <= '0;
            vote_inp    <= 4'b0000;
            vote_strobe <= 1'b0;
            multi_press <= 1'b0;
            busy        <= 1'b0;
            vote_count  <= '0;
        end else begin
            vote_inp    <= 4'b0000;
            vote_strobe <= 1'b0;
            multi_press <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_s != 4'b0000) begin
                        cand  <= btn_s;
                        cnt   <= CNT_W'(1);
                        state <= DEBOUNCE;
                        busy  <= 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (btn_s == 4'b0000) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (btn_s != cand) begin
                        cand <= btn_s;
                        cnt  <= CNT_W'(1);
                    end else if (cnt == CNT_LAST) begin
                        state <= EMIT;
                        lcnt  <= '0;
                        if (cand_onehot) begin
                            vote_inp    <= cand;
                            vote_strobe <= 1'b1;
                            if (vote_count != {COUNT_W{1'b1}})
                                vote_count <= vote_count + COUNT_W'(1);
                        end else begin
                            multi_press <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                EMIT: begin
                    state <= WAIT_RELEASE;
                    lcnt  <= '0;
                end
                WAIT_RELEASE: begin
                    // Any activity restarts the release window; held buttons never re-vote.
                    if (btn_s != 4'b0000) begin
                        lcnt <= '0;
                    end else if (lcnt == LCNT_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        lcnt <= lcnt + LCNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vote_input_conditioner.sv
// Scoreboard bench for vote_input_conditioner: directed presses push expected pulses,
// a negedge monitor pops and compares them, plus a COUNT_W=3 copy for saturation.
module tb_vote_input_conditioner;

    logic       clk;
    logic       RESET;
    logic [3:0] btn;

    logic [3:0] vote_inp;
    logic       vote_strobe;
    logic       multi_press;
    logic       busy;
    logic [7:0] vote_count;

    logic [3:0] vote_inp_s;
    logic       vote_strobe_s;
    logic       multi_press_s;
    logic       busy_s;
    logic [2:0] vote_count_s;

    vote_input_conditioner #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(2), .COUNT_W(8)) dut (
        .clk(clk), .RESET(RESET), .btn(btn),
        .vote_inp(vote_inp), .vote_strobe(vote_strobe), .multi_press(multi_press),
        .busy(busy), .vote_count(vote_count)
    );

    vote_input_conditioner #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(2), .COUNT_W(3)) dut_s (
        .clk(clk), .RESET(RESET), .btn(btn),
        .vote_inp(vote_inp_s), .vote_strobe(vote_strobe_s), .multi_press(multi_press_s),
        .busy(busy_s), .vote_count(vote_count_s)
    );

    typedef struct packed {
        logic        multi;
        logic [3:0]  v;
        logic [7:0]  cnt;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    int          checks = 0;
    int          passes = 0;
    logic [31:0] cyc = 0;
    logic        prev_pulse = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: pops the next expected pulse whenever the DUT emits one.
    always @(negedge clk) begin
        if (RESET) begin
            prev_pulse <= 1'b0;
        end else begin
            chk("exclusive", 32'(vote_strobe & multi_press), 32'd0);
            chk("spacing", 32'(prev_pulse & (vote_strobe | multi_press)), 32'd0);
            chk("sat_twin_strobe", 32'(vote_strobe_s), 32'(vote_strobe));
            chk("sat_twin_multi", 32'(multi_press_s), 32'(multi_press));
            chk("sat_twin_busy", 32'(busy_s), 32'(busy));
            chk("sat_twin_inp", 32'(vote_inp_s), 32'(vote_inp));
            if (vote_strobe || multi_press) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_pulse", 32'(vote_inp), 32'hffff_ffff);
                end else begin
                    e = sbq.pop_front();
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("pulse_kind_multi", 32'(multi_press), 32'(e.multi));
                    chk("pulse_kind_strobe", 32'(vote_strobe), 32'(!e.multi));
                    chk("vote_inp", 32'(vote_inp), 32'(e.v));
                    chk("vote_count", 32'(vote_count), 32'(e.cnt));
                    chk("vote_count_sat", 32'(vote_count_s),
                        (e.cnt > 8'd7) ? 32'd7 : 32'(e.cnt));
                end
            end else begin
                chk("idle_vote_inp", 32'(vote_inp), 32'd0);
            end
            prev_pulse <= vote_strobe | multi_press;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick(2);
        RESET = 1'b0;
        chk("rst_vote_count", 32'(vote_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strobe", 32'(vote_strobe), 32'd0);
    endtask

    task automatic expect_pulse(input logic multi, input logic [3:0] v, input logic [7:0] cnt);
        exp_t x;
        x.multi = multi;
        x.v     = multi ? 4'b0000 : v;
        x.cnt   = cnt;
        x.cyc   = cyc + 32'd6;
        sbq.push_back(x);
    endtask

    task automatic press(input logic [3:0] v, input int hold, input logic multi,
                         input logic [7:0] cnt);
        btn = v;
        expect_pulse(multi, v, cnt);
        tick(hold);
        btn = 4'b0000;
        tick(6);
    endtask

    initial begin
        btn   = 4'b0000;
        RESET = 1'b1;

        // Clean press
        do_reset();
        press(4'b0001, 10, 1'b0, 8'd1);
        chk("clean_count", 32'(vote_count), 32'd1);

        // Bounce: two samples, a gap, then a stable press
        do_reset();
        btn = 4'b0010;
        tick(2);
        btn = 4'b0000;
        tick(1);
        press(4'b0010, 8, 1'b0, 8'd1);
        chk("bounce_count", 32'(vote_count), 32'd1);

        // Multi-press
        do_reset();
        press(4'b0011, 8, 1'b1, 8'd0);
        chk("multi_count", 32'(vote_count), 32'd0);

        // Hold and lockout
        do_reset();
        btn = 4'b1000;
        expect_pulse(1'b0, 4'b1000, 8'd1);
        tick(10);
        chk("hold_busy", 32'(busy), 32'd1);
        tick(10);
        btn = 4'b0000;
        tick(1);
        btn = 4'b0100;
        tick(10);
        chk("lockout_busy", 32'(busy), 32'd1);
        btn = 4'b0000;
        tick(3);
        press(4'b0100, 8, 1'b0, 8'd2);
        chk("lockout_count", 32'(vote_count), 32'd2);
        chk("lockout_idle", 32'(busy), 32'd0);

        // Reset mid-debounce drops the candidate and requalifies from scratch
        btn = 4'b0001;
        tick(3);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        RESET = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_count", 32'(vote_count), 32'd0);
        chk("midrst_count_sat", 32'(vote_count_s), 32'd0);
        chk("midrst_vote_inp", 32'(vote_inp), 32'd0);
        chk("midrst_flags", 32'({vote_strobe, multi_press}), 32'd0);
        tick(2);
        RESET = 1'b0;
        expect_pulse(1'b0, 4'b0001, 8'd1);
        tick(10);
        btn = 4'b0000;
        tick(6);
        chk("postrst_count", 32'(vote_count), 32'd1);

        // Saturation on the COUNT_W=3 copy
        do_reset();
        for (int i = 0; i < 9; i++) press(4'b0001, 8, 1'b0, 8'(i + 1));
        chk("sat_final", 32'(vote_count_s), 32'd7);
        chk("sat_wide_final", 32'(vote_count), 32'd9);

        for (int i = 0; i < 50; i++) begin
            if (sbq.size() == 0) break;
            tick(1);
        end
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
